collision_hit_filter: RTL and testbench

- Upstream stage of the Pac-Man HP counter.
- Turns the raw per-pixel overlap of the Pac-Man and red-monster drawing requests into at most one single-cycle hit pulse (collision_mp) per VGA frame.
- After each hit, enforces a post-hit invulnerability window of fixed frame count, during which no hits are issued.
- Drives a blink flag so the Pac-Man sprite flashes while invulnerable.

---
 rtl/collision_hit_filter.sv | 127 ++++++++++++
 tb/tb_collision_hit_filter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/collision_hit_filter.sv
// collision_hit_filter
// Converts the per-pixel overlap of the Pac-Man and red-monster drawing
// requests into at most one single-cycle hit pulse per VGA frame. After a
// hit it blocks further hits for INVULN_FRAMES frame boundaries and blinks
// the Pac-Man sprite during that time.
//
// Ports:
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-clk pulse at each VGA frame boundary
//   pacman_dr     Pac-Man drawing request for the current pixel
//   monster_dr    red-monster drawing request for the current pixel
//   stop_gameN    active-low synchronous freeze (pause / game over)
//   collision_mp  one-clk hit pulse to the HP counter
//   invulnerable  high while in the post-hit invulnerability window
//   blink_off     1 = Pac-Man sprite must be hidden this frame
module collision_hit_filter #(
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic pacman_dr,
  input  logic monster_dr,
  input  logic stop_gameN,
  output logic collision_mp,
  output logic invulnerable,
  output logic blink_off
);

  localparam int FRAME_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {
    ARMED  = 1'b0,
    INVULN = 1'b1
  } state_t;

  state_t             state_q,        state_d;
  logic               hit_flag_q,     hit_flag_d;
  logic [FRAME_W-1:0] frame_cnt_q,    frame_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q,    blink_cnt_d;
  logic               blink_off_q,    blink_off_d;
  logic               collision_mp_q, collision_mp_d;

  logic coin;
  assign coin = pacman_dr & monster_dr;

  always_comb begin
    state_d        = state_q;
    hit_flag_d     = hit_flag_q;
    frame_cnt_d    = frame_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    blink_off_d    = blink_off_q;
    collision_mp_d = 1'b0;

    if (!stop_gameN) begin
      // Freeze: everything holds except the pending-hit flag, which is
      // dropped so an overlap straddling the pause is never reported.
      hit_flag_d = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (startOfFrame) begin
            // An overlap on the boundary cycle belongs to the frame that ends.
            hit_flag_d = 1'b0;
            if (hit_flag_q | coin) begin
              collision_mp_d = 1'b1;
              state_d        = INVULN;
              frame_cnt_d    = FRAME_W'(INVULN_FRAMES);
              blink_cnt_d    = '0;
              blink_off_d    = 1'b1;
            end
          end else begin
            hit_flag_d = hit_flag_q | coin;
          end
        end

        INVULN: begin
          hit_flag_d = 1'b0;
          if (startOfFrame) begin
            if (frame_cnt_q == FRAME_W'(1)) begin
              frame_cnt_d = '0;
              state_d     = ARMED;
              blink_off_d = 1'b0;
              blink_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q - FRAME_W'(1);
              if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
              end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
              end
            end
          end
        end

        default: state_d = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ARMED;
      hit_flag_q     <= 1'b0;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      collision_mp_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hit_flag_q     <= hit_flag_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_off_q    <= blink_off_d;
      collision_mp_q <= collision_mp_d;
    end
  end

  assign collision_mp = collision_mp_q;
  assign invulnerable = (state_q == INVULN);
  assign blink_off    = blink_off_q;

endmodule

// File: tb/tb_collision_hit_filter.sv
// tb_collision_hit_filter
// Directed bench for collision_hit_filter with INVULN_FRAMES=4,
// BLINK_FRAMES=2 and 100-clk frames. Each table step drives a run of
// cycles (startOfFrame only on the first), checks the outputs right after
// that first cycle and counts hit pulses over the whole step. A
// hand-written sequence covers asynchronous reset in mid-invulnerability.
module tb_collision_hit_filter;

  logic clk = 1'b0;
  logic resetN;
  logic startOfFrame;
  logic pacman_dr;
  logic monster_dr;
  logic stop_gameN;
  logic collision_mp;
  logic invulnerable;
  logic blink_off;

  int n_checks = 0;
  int n_fail   = 0;

  collision_hit_filter #(
    .INVULN_FRAMES(4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .pacman_dr   (pacman_dr),
    .monster_dr  (monster_dr),
    .stop_gameN  (stop_gameN),
    .collision_mp(collision_mp),
    .invulnerable(invulnerable),
    .blink_off   (blink_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    bit    sof;
    bit    pac;
    bit    mon;
    bit    frz;
    bit    e_coll;
    bit    e_inv;
    bit    e_blink;
    int    e_pulses;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, int len, bit sof, bit pac, bit mon,
                              bit frz, bit e_coll, bit e_inv, bit e_blink,
                              int e_pulses);
    vec_t v;
    v.name = name; v.len = len; v.sof = sof; v.pac = pac; v.mon = mon;
    v.frz = frz; v.e_coll = e_coll; v.e_inv = e_inv; v.e_blink = e_blink;
    v.e_pulses = e_pulses;
    return v;
  endfunction

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: inputs were set beforehand, outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              name          len  sof pac mon frz coll inv blk pulses
    vecs.push_back(mk("f0_idle",     35, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f0_coin",     30, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f0_tail",     35, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f1_hit",     100, 1, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk("f2",         100, 1, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("f3",         100, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f4",         100, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f5_rearm",   100, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f6_sofcoin",   1, 1, 1, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk("f6_rest",     99, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("f7_sofcoin",   1, 1, 1, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk("f7_rest",     99, 0, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk("f8",         100, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f9_frz",     100, 1, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("f10_frz",    100, 1, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("f11_frz",    100, 1, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("f12",        100, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f13_rearm",   50, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f13_coin",    30, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f13_frz",     20, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("f14_frz",     10, 1, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("f14_pac",     45, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f14_mon",     45, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f15_idle",    50, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f15_coin",    50, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f16_hit",    100, 1, 1, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk("f17",        100, 1, 1, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk("f18",        100, 1, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f19",        100, 1, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk("f20_rearm",  100, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("f21_hit",     40, 1, 1, 1, 0, 1, 1, 1, 1));

    // Reset state
    resetN = 1'b0; startOfFrame = 1'b0; pacman_dr = 1'b0;
    monster_dr = 1'b0; stop_gameN = 1'b1;
    #2;
    check("rst_coll",  collision_mp, 0);
    check("rst_inv",   invulnerable, 0);
    check("rst_blink", blink_off,    0);
    tick(); tick();
    resetN = 1'b1;

    foreach (vecs[i]) begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < vecs[i].len; c++) begin
        startOfFrame = vecs[i].sof && (c == 0);
        pacman_dr    = vecs[i].pac;
        monster_dr   = vecs[i].mon;
        stop_gameN   = !vecs[i].frz;
        tick();
        if (c == 0) begin
          check({vecs[i].name, "_coll"},  collision_mp, vecs[i].e_coll);
          check({vecs[i].name, "_inv"},   invulnerable, vecs[i].e_inv);
          check({vecs[i].name, "_blink"}, blink_off,    vecs[i].e_blink);
        end
        if (collision_mp) pulses++;
      end
      check({vecs[i].name, "_pulses"}, pulses, vecs[i].e_pulses);
      $display("step %-12s len=%0d sof=%0d pac=%0d mon=%0d frz=%0d pulses=%0d inv=%0d blink=%0d",
               vecs[i].name, vecs[i].len, vecs[i].sof, vecs[i].pac,
               vecs[i].mon, vecs[i].frz, pulses, invulnerable, blink_off);
    end

    // Asynchronous reset mid-invulnerability (blink_off=1 here)
    startOfFrame = 1'b0; pacman_dr = 1'b0; monster_dr = 1'b0;
    check("pre_rst_blink", blink_off, 1);
    #3;
    resetN = 1'b0;
    #1;
    check("arst_coll",  collision_mp, 0);
    check("arst_inv",   invulnerable, 0);
    check("arst_blink", blink_off,    0);
    $display("async reset applied mid-frame: coll=%0d inv=%0d blink=%0d",
             collision_mp, invulnerable, blink_off);
    tick(); tick();
    resetN = 1'b1;
    pacman_dr = 1'b1; monster_dr = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check("post_rst_nopulse", collision_mp, 0);
    pacman_dr = 1'b0; monster_dr = 1'b0; startOfFrame = 1'b1;
    tick();
    check("post_rst_coll",  collision_mp, 1);
    check("post_rst_inv",   invulnerable, 1);
    check("post_rst_blink", blink_off,    1);
    startOfFrame = 1'b0;
    tick();
    check("post_rst_width", collision_mp, 0);
    $display("post-reset hit: coll pulse seen after boundary, inv=%0d blink=%0d",
             invulnerable, blink_off);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
